// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: opcode field
// layout, the relative-jump opcode and the FSM state encoding.
package fetch_sequencer_pkg;

    // Instruction fields: [7:6] opcode, [5:0] signed jump offset.
    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 6;
    localparam int OFFS_HI = 5;
    localparam int OFFS_LO = 0;

    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_jump(input logic [7:0] instr);
        return instr[OPC_HI:OPC_LO] == OP_JUMP;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: control inputs from the pipeline, the instruction
// memory read port, and the IF/ID register outputs.
//   master : pipeline/memory side (drives Start, Stall_In, Redirect_*, Instr_In)
//   slave  : fetch_sequencer side (drives PC_Out, Fetch_En, IF_ID_*, status)
interface fetch_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 8
);
    logic              Start;
    logic              Stall_In;
    logic              Redirect_En;
    logic [PC_W-1:0]   Redirect_Addr;
    logic [7:0]        Instr_In;
    logic [PC_W-1:0]   PC_Out;
    logic              Fetch_En;
    logic [7:0]        IF_ID_Instr;
    logic [PC_W-1:0]   IF_ID_PC;
    logic              IF_ID_Valid;
    logic              Busy;
    logic              Done;
    logic [CNT_W-1:0]  Fetch_Count;

    modport master (
        output Start, Stall_In, Redirect_En, Redirect_Addr, Instr_In,
        input  PC_Out, Fetch_En, IF_ID_Instr, IF_ID_PC, IF_ID_Valid,
               Busy, Done, Fetch_Count
    );

    modport slave (
        input  Start, Stall_In, Redirect_En, Redirect_Addr, Instr_In,
        output PC_Out, Fetch_En, IF_ID_Instr, IF_ID_PC, IF_ID_Valid,
               Busy, Done, Fetch_Count
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Next fetch address: PC+1, or PC+1+sext(offset) for the relative jump.
// Arithmetic wraps modulo 2^PC_W; past_end flags an address beyond the
// program image, which terminates the program.
//   pc       : current fetch address
//   instr    : instruction word read at pc
//   next_pc  : address to fetch next
//   past_end : next_pc >= MEM_DEPTH
module fetch_sequencer_next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int MEM_DEPTH = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      instr,
    output logic [PC_W-1:0] next_pc,
    output logic            past_end
);
    // One extra bit so MEM_DEPTH == 2^PC_W is representable.
    localparam logic [PC_W:0] DEPTH = (PC_W+1)'(MEM_DEPTH);

    logic [PC_W-1:0] offs;

    always_comb begin
        offs     = '0;
        if (is_jump(instr))
            offs = {{(PC_W-6){instr[OFFS_HI]}}, instr[OFFS_HI:OFFS_LO]};
        next_pc  = pc + PC_W'(1) + offs;
        past_end = {1'b0, next_pc} >= DEPTH;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage controller. Owns the PC, drives the memory read
// address, latches fetched words into IF/ID and resolves the relative jump
// at fetch so a taken jump costs no bubble.
//   Clk, Reset : clock, async active-low reset
//   bus        : fetch bus (slave side), see fetch_sequencer_if
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int MEM_DEPTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    fetch_sequencer_if.slave bus
);
    localparam logic [PC_W:0] DEPTH = (PC_W+1)'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ifid_instr;
    logic [PC_W-1:0]   ifid_pc;
    logic              ifid_vld;
    logic [CNT_W-1:0]  cnt;

    logic              start_go, redir_go, fetch_go;
    logic [PC_W-1:0]   next_pc;
    logic              past_end, redir_past;

    fetch_sequencer_next_pc_calc #(
        .PC_W      (PC_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_npc (
        .pc       (pc),
        .instr    (bus.Instr_In),
        .next_pc  (next_pc),
        .past_end (past_end)
    );

    assign redir_past = {1'b0, bus.Redirect_Addr} >= DEPTH;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Redirect beats stall beats fetch; Start only matters outside FETCH.
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        redir_go  = 1'b0;
        fetch_go  = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    state_nxt = ST_FETCH;
                    start_go  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.Redirect_En) begin
                    redir_go = 1'b1;
                    if (redir_past) state_nxt = ST_DONE;
                end else if (!bus.Stall_In) begin
                    fetch_go = 1'b1;
                    if (past_end) state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc         <= '0;
            ifid_instr <= 8'h00;
            ifid_pc    <= '0;
            ifid_vld   <= 1'b0;
            cnt        <= '0;
        end else if (start_go) begin
            pc       <= '0;
            cnt      <= '0;
            ifid_vld <= 1'b0;
        end else if (redir_go) begin
            // Redirect flushes IF/ID valid but leaves the stale word in place.
            pc       <= bus.Redirect_Addr;
            ifid_vld <= 1'b0;
        end else if (fetch_go) begin
            ifid_instr <= bus.Instr_In;
            ifid_pc    <= pc;
            ifid_vld   <= 1'b1;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            // On running off the end the PC stays on the last address.
            if (!past_end) pc <= next_pc;
        end else if (state != ST_FETCH) begin
            // Final word is shown for exactly one cycle once in DONE.
            ifid_vld <= 1'b0;
        end
    end

    assign bus.PC_Out      = pc;
    assign bus.Fetch_En    = fetch_go;
    assign bus.IF_ID_Instr = ifid_instr;
    assign bus.IF_ID_PC    = ifid_pc;
    assign bus.IF_ID_Valid = ifid_vld;
    assign bus.Busy        = (state == ST_FETCH);
    assign bus.Done        = (state == ST_DONE);
    assign bus.Fetch_Count = cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    typedef struct {
        logic [7:0] pc;
        logic [7:0] ins;
    } vec_t;

    logic Clk;
    logic Reset;
    logic [7:0] mem [8];

    fetch_sequencer_if #(.PC_W(8), .CNT_W(8)) bus ();

    fetch_sequencer #(.PC_W(8), .MEM_DEPTH(8), .CNT_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    assign bus.Instr_In = (bus.PC_Out < 8'd8) ? mem[bus.PC_Out[2:0]] : 8'h00;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model state (0 idle, 1 fetch, 2 done).
    int m_state, m_pc, m_cnt, m_vld;
    vec_t sb [$];
    vec_t log_q [$];
    vec_t run_tab [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic load_image();
        mem[0] = 8'h33; mem[1] = 8'h71; mem[2] = 8'h1C; mem[3] = 8'hC1;
        mem[4] = 8'h5B; mem[5] = 8'h02; mem[6] = 8'h0B; mem[7] = 8'h01;
    endtask

    // One clock: drive at negedge, check comb outputs, step model,
    // then check registered outputs just after posedge.
    task automatic tick(input logic st, input logic sl, input logic rd, input logic [7:0] ra);
        vec_t e;
        logic pushed;
        int ins, off, np;
        bus.Start = st; bus.Stall_In = sl; bus.Redirect_En = rd; bus.Redirect_Addr = ra;
        #1;
        chk("fetch_en", 32'(bus.Fetch_En), 32'(m_state == 1 && !sl && !rd));
        chk("pc_out", 32'(bus.PC_Out), m_pc);
        pushed = 1'b0;
        if (m_state != 1) begin
            m_vld = 0;
            if (st) begin m_state = 1; m_pc = 0; m_cnt = 0; end
        end else if (rd) begin
            m_pc = int'(ra); m_vld = 0;
            if (m_pc >= 8) m_state = 2;
        end else if (!sl) begin
            ins = int'(mem[m_pc[2:0]]);
            e.pc = 8'(m_pc); e.ins = 8'(ins);
            sb.push_back(e); pushed = 1'b1;
            m_vld = 1;
            if (m_cnt < 255) m_cnt++;
            off = int'(ins[5:0]);
            if (ins[5]) off = off - 64;
            np = (ins[7:6] == 2'b11) ? ((m_pc + 1 + off) & 255) : m_pc + 1;
            if (np >= 8) m_state = 2; else m_pc = np;
        end
        @(posedge Clk); #1;
        chk("if_id_valid", 32'(bus.IF_ID_Valid), m_vld);
        chk("fetch_count", 32'(bus.Fetch_Count), m_cnt);
        chk("busy", 32'(bus.Busy), 32'(m_state == 1));
        chk("done", 32'(bus.Done), 32'(m_state == 2));
        chk("pc_next", 32'(bus.PC_Out), m_pc);
        if (pushed) begin
            e = sb.pop_front();
            chk("if_id_instr", 32'(bus.IF_ID_Instr), 32'(e.ins));
            chk("if_id_pc", 32'(bus.IF_ID_PC), 32'(e.pc));
        end
        if (bus.IF_ID_Valid) begin
            e.pc = bus.IF_ID_PC; e.ins = bus.IF_ID_Instr;
            log_q.push_back(e);
        end
        @(negedge Clk);
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && m_state != 2; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("run_done", 32'(bus.Done), 32'd1);
    endtask

    initial begin
        run_tab[0] = '{8'd0, 8'h33}; run_tab[1] = '{8'd1, 8'h71};
        run_tab[2] = '{8'd2, 8'h1C}; run_tab[3] = '{8'd3, 8'hC1};
        run_tab[4] = '{8'd5, 8'h02}; run_tab[5] = '{8'd6, 8'h0B};
        run_tab[6] = '{8'd7, 8'h01};
        load_image();
        m_state = 0; m_pc = 0; m_cnt = 0; m_vld = 0;
        Reset = 1'b0;
        bus.Start = 1'b0; bus.Stall_In = 1'b0; bus.Redirect_En = 1'b0; bus.Redirect_Addr = 8'h00;

        // Reset values
        #2;
        chk("rst_pc", 32'(bus.PC_Out), 32'd0);
        chk("rst_valid", 32'(bus.IF_ID_Valid), 32'd0);
        chk("rst_instr", 32'(bus.IF_ID_Instr), 32'h00);
        chk("rst_count", 32'(bus.Fetch_Count), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // IDLE ignores everything but Start
        tick(1'b0, 1'b1, 1'b1, 8'h05);
        tick(1'b0, 1'b0, 1'b1, 8'h03);

        // Straight run, compared against the table
        log_q.delete();
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        run_to_done(20);
        tick(1'b0, 1'b1, 1'b1, 8'h02);
        chk("run_len", 32'(log_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) begin
                chk("run_tab_pc", 32'(log_q[i].pc), 32'(run_tab[i].pc));
                chk("run_tab_instr", 32'(log_q[i].ins), 32'(run_tab[i].ins));
            end
        end
        chk("run_count", 32'(bus.Fetch_Count), 32'd7);

        // Restart from DONE, stall at PC 2, Start during FETCH ignored
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        chk("stall_pc", 32'(bus.PC_Out), 32'd2);
        chk("stall_instr", 32'(bus.IF_ID_Instr), 32'h71);
        chk("stall_valid", 32'(bus.IF_ID_Valid), 32'd1);
        chk("stall_count", 32'(bus.Fetch_Count), 32'd2);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("resume_instr", 32'(bus.IF_ID_Instr), 32'h1C);
        run_to_done(20);

        // Redirect wins over stall
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h06);
        chk("redir_pc", 32'(bus.PC_Out), 32'd6);
        chk("redir_valid", 32'(bus.IF_ID_Valid), 32'd0);
        chk("redir_keep_instr", 32'(bus.IF_ID_Instr), 32'h33);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("redir_instr", 32'(bus.IF_ID_Instr), 32'h0B);
        run_to_done(20);

        // Backward jump loop, counter saturates, never DONE
        mem[2] = 8'hFE;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("loop_sat", 32'(bus.Fetch_Count), 32'd255);
        chk("loop_not_done", 32'(bus.Done), 32'd0);
        // Redirect past the image ends the program
        tick(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("redir_end_done", 32'(bus.Done), 32'd1);
        load_image();

        // Forward jump far beyond image: one fetch then DONE
        mem[0] = 8'hDF;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("far_fwd_done", 32'(bus.Done), 32'd1);
        chk("far_fwd_count", 32'(bus.Fetch_Count), 32'd1);
        // Backward jump wrapping below zero: also leaves the image
        mem[0] = 8'hE0;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap_done", 32'(bus.Done), 32'd1);
        chk("wrap_pc_hold", 32'(bus.PC_Out), 32'd0);
        load_image();

        // Async reset mid-run at PC 5
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20 && !(m_state == 1 && m_pc == 5); i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pre_rst_pc", 32'(bus.PC_Out), 32'd5);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(bus.PC_Out), 32'd0);
        chk("mid_rst_valid", 32'(bus.IF_ID_Valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        chk("mid_rst_count", 32'(bus.Fetch_Count), 32'd0);
        chk("mid_rst_fetch_en", 32'(bus.Fetch_En), 32'd0);
        m_state = 0; m_pc = 0; m_cnt = 0; m_vld = 0;
        sb.delete();
        @(negedge Clk);
        Reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h04);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        run_to_done(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
